adder_result_fifo: RTL and testbench

//   Downstream stage of adder_four_bit: captures each {cout,sum} result into a

---
 rtl/adder_result_fifo.sv | 135 +++++++++++++
 tb/tb_adder_result_fifo.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/adder_result_fifo.sv
// Generic FWFT FIFO: push/pop pre-qualified by the caller, synchronous flush.
// Latency: a written entry is readable on rd_dat the cycle after the write edge.
// Backpressure: full/empty are exported; the caller must not push when full or pop when empty.
module fifo #(
    parameter int W     = 5,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wr_dat,
    output logic [W-1:0]               rd_dat,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            // push and pop together leave the occupancy untouched
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign full   = (count == FULL_CNT);
    assign empty  = (count == '0);
    // stale storage is masked so the outputs read zero while empty
    assign rd_dat = empty ? '0 : mem[rd_ptr];
endmodule

// Buffers adder {cout,sum} results in order and counts accepted carries (saturating).
// Latency: a result pushed into an empty FIFO appears on out_* right after the push edge.
// Backpressure: in_ready drops only when full and never looks at out_ready.
module adder_result_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_sum,
    input  logic                       in_cout,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_sum,
    output logic                       out_cout,
    output logic [$clog2(DEPTH):0]     count,
    output logic [CNT_W-1:0]           carry_cnt
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [WIDTH:0]   head;

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    fifo #(
        .W     (WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (clear),
        .push   (push),
        .pop    (pop),
        .wr_dat ({in_cout, in_sum}),
        .rd_dat (head),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

    assign out_cout = head[WIDTH];
    assign out_sum  = head[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_cnt <= '0;
        end else if (clear) begin
            carry_cnt <= '0;
        end else if (push && in_cout && (carry_cnt != CNT_MAX)) begin
            carry_cnt <= carry_cnt + CNT_W'(1);
        end
    end

    // A stalled producer must hold its result until it is accepted.
    property p_hold_stalled;
        @(posedge clk) disable iff (!rst_n)
            (in_valid && !in_ready && !clear) |=>
                (!in_valid || ({in_cout, in_sum} == $past({in_cout, in_sum})));
    endproperty
    a_hold_stalled: assert property (p_hold_stalled);
endmodule

// File: tb/tb_adder_result_fifo.sv
module tb_adder_result_fifo;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       in_valid;
    logic [3:0] in_sum;
    logic       in_cout;
    logic       out_ready;
    logic       in_ready, out_valid, out_cout;
    logic [3:0] out_sum;
    logic [2:0] count;
    logic [7:0] carry_cnt;
    logic       in_ready2, out_valid2, out_cout2;
    logic [3:0] out_sum2;
    logic [2:0] count2;
    logic [1:0] carry_cnt2;

    adder_result_fifo #(.WIDTH(4), .DEPTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum), .in_cout(in_cout),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout),
        .count(count), .carry_cnt(carry_cnt)
    );

    adder_result_fifo #(.WIDTH(4), .DEPTH(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready2), .in_sum(in_sum), .in_cout(in_cout),
        .out_valid(out_valid2), .out_ready(out_ready), .out_sum(out_sum2), .out_cout(out_cout2),
        .count(count2), .carry_cnt(carry_cnt2)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [4:0] q[$];
    int mc = 0;

    typedef struct {
        int v; int s; int c; int ordy; int clr;
        int e_cnt; int e_ov; int e_sum; int e_cout; int e_ir; int e_carry;
    } vec_t;
    vec_t tbl[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int v, input int s, input int c, input int r, input int cl);
        in_valid  = (v != 0);
        in_sum    = 4'(s);
        in_cout   = (c != 0);
        out_ready = (r != 0);
        clear     = (cl != 0);
    endtask

    task automatic model_cmp(input string tag);
        int n;
        logic [4:0] h;
        n = q.size();
        h = (n != 0) ? q[0] : 5'd0;
        check({tag, ".count"},     32'(count),      32'(n));
        check({tag, ".out_valid"}, 32'(out_valid),  32'(n != 0));
        check({tag, ".out_sum"},   32'(out_sum),    32'(h[3:0]));
        check({tag, ".out_cout"},  32'(out_cout),   32'(h[4]));
        check({tag, ".in_ready"},  32'(in_ready),   32'(n != DEPTH));
        check({tag, ".carry_cnt"}, 32'(carry_cnt),  32'((mc > 255) ? 255 : mc));
        check({tag, ".carry_sat"}, 32'(carry_cnt2), 32'((mc > 3) ? 3 : mc));
        check({tag, ".count2"},    32'(count2),     32'(n));
    endtask

    // One clock edge: the queue model follows the handshake rules, then outputs are compared.
    task automatic step(input string tag);
        bit pu;
        bit po;
        @(posedge clk);
        pu = in_valid && (q.size() != DEPTH);
        po = out_ready && (q.size() != 0);
        if (clear) begin
            q.delete();
            mc = 0;
        end else begin
            if (po) void'(q.pop_front());
            if (pu) begin
                q.push_back({in_cout, in_sum});
                if (in_cout) mc++;
            end
        end
        #1;
        model_cmp(tag);
    endtask

    initial begin
        bit stall;
        bit stall_next;
        string tg;

        // v s c ordy clr | count ov sum cout ir carry
        tbl[0]  = '{1, 1, 0, 1, 0,  1, 1, 1, 0, 1, 0};
        tbl[1]  = '{0, 0, 0, 1, 0,  0, 0, 0, 0, 1, 0};
        tbl[2]  = '{1, 1, 0, 0, 0,  1, 1, 1, 0, 1, 0};
        tbl[3]  = '{1, 2, 0, 0, 0,  2, 1, 1, 0, 1, 0};
        tbl[4]  = '{1, 3, 0, 0, 0,  3, 1, 1, 0, 1, 0};
        tbl[5]  = '{1, 9, 0, 0, 0,  4, 1, 1, 0, 0, 0};
        tbl[6]  = '{1, 5, 0, 0, 0,  4, 1, 1, 0, 0, 0};
        tbl[7]  = '{0, 0, 0, 1, 0,  3, 1, 2, 0, 1, 0};
        tbl[8]  = '{0, 0, 0, 1, 0,  2, 1, 3, 0, 1, 0};
        tbl[9]  = '{0, 0, 0, 1, 0,  1, 1, 9, 0, 1, 0};
        tbl[10] = '{0, 0, 0, 1, 0,  0, 0, 0, 0, 1, 0};
        tbl[11] = '{1, 7, 1, 0, 0,  1, 1, 7, 1, 1, 1};
        tbl[12] = '{1, 8, 0, 0, 0,  2, 1, 7, 1, 1, 1};
        tbl[13] = '{1, 10, 0, 1, 0, 2, 1, 8, 0, 1, 1};

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        #12;
        check("reset.count",     32'(count),     32'd0);
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.in_ready",  32'(in_ready),  32'd1);
        check("reset.carry_cnt", 32'(carry_cnt), 32'd0);
        check("reset.out_sum",   32'(out_sum),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].v, tbl[i].s, tbl[i].c, tbl[i].ordy, tbl[i].clr);
            tg = $sformatf("tbl%0d", i);
            step(tg);
            check({tg, ".exp_count"}, 32'(count),     32'(tbl[i].e_cnt));
            check({tg, ".exp_ov"},    32'(out_valid), 32'(tbl[i].e_ov));
            check({tg, ".exp_sum"},   32'(out_sum),   32'(tbl[i].e_sum));
            check({tg, ".exp_cout"},  32'(out_cout),  32'(tbl[i].e_cout));
            check({tg, ".exp_ir"},    32'(in_ready),  32'(tbl[i].e_ir));
            check({tg, ".exp_carry"}, 32'(carry_cnt), 32'(tbl[i].e_carry));
        end

        // Simultaneous push/pop at count=2 across several pointer wraps.
        for (int i = 0; i < 10; i++) begin
            drive(1, i + 3, 0, 1, 0);
            step($sformatf("wrap%0d", i));
            check($sformatf("wrap%0d.hold2", i), 32'(count), 32'd2);
        end

        // Carry counting and saturation on the narrow instance.
        drive(0, 0, 0, 0, 1);
        step("carry_clr");
        for (int i = 0; i < 5; i++) begin
            drive(1, 9, 1, 1, 0);
            step($sformatf("carry%0d", i));
            if (i == 2) begin
                check("carry3.wide", 32'(carry_cnt),  32'd3);
                check("carry3.narrow", 32'(carry_cnt2), 32'd3);
            end
        end
        check("carry5.wide",   32'(carry_cnt),  32'd5);
        check("carry5.narrow", 32'(carry_cnt2), 32'd3);

        // Clear beats a concurrent push.
        drive(0, 0, 0, 0, 1);
        step("clr_pre");
        for (int i = 0; i < 3; i++) begin
            drive(1, i + 1, 1, 0, 0);
            step($sformatf("clr_fill%0d", i));
        end
        check("clr.count3", 32'(count), 32'd3);
        drive(1, 6, 1, 1, 1);
        step("clr_edge");
        check("clr.count",     32'(count),     32'd0);
        check("clr.carry_cnt", 32'(carry_cnt), 32'd0);
        check("clr.out_valid", 32'(out_valid), 32'd0);
        drive(0, 0, 0, 0, 0);
        step("clr_after");
        check("clr.no_push", 32'(count), 32'd0);

        // Asynchronous reset mid-stream, observed before any clock edge.
        for (int i = 0; i < 3; i++) begin
            drive(1, 12 + i, 1, 0, 0);
            step($sformatf("rst_fill%0d", i));
        end
        check("rst.count3", 32'(count), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async.count",     32'(count),      32'd0);
        check("rst_async.out_valid", 32'(out_valid),  32'd0);
        check("rst_async.in_ready",  32'(in_ready),   32'd1);
        check("rst_async.carry_cnt", 32'(carry_cnt),  32'd0);
        check("rst_async.carry_sat", 32'(carry_cnt2), 32'd0);
        check("rst_async.out_sum",   32'(out_sum),    32'd0);
        q.delete();
        mc = 0;
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic against the queue model; stalled data is held.
        stall = 1'b0;
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 9) < 6);
            out_ready = ($urandom_range(0, 9) < 5);
            clear     = ($urandom_range(0, 39) == 0);
            if (!stall) begin
                in_sum  = 4'($urandom_range(0, 15));
                in_cout = ($urandom_range(0, 2) != 0);
            end
            stall_next = in_valid && !in_ready && !clear;
            step($sformatf("rnd%0d", i));
            stall = stall_next;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
